// File: rtl/npc_pkg.sv
// Shared decode constants for the NPC core: opcodes, unit codes and the
// per-instruction control bundle carried from decode to execute.
package npc_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;

  typedef enum logic [3:0] {
    FU_ALU   = 4'd0,
    FU_ALUW  = 4'd1,
    FU_MUL   = 4'd2,
    FU_MULW  = 4'd3,
    FU_BR    = 4'd4,
    FU_JAL   = 4'd5,
    FU_JALR  = 4'd6,
    FU_LOAD  = 4'd7,
    FU_STORE = 4'd8,
    FU_NONE  = 4'd9
  } fu_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  // The immediate and PC are XLEN-wide, so they travel beside this bundle.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_en;
    logic       rs2_en;
    logic       pc_en;
    logic       imm_en;
    fu_sel_e    fu_sel;
    logic [4:0] fu_op;
    logic       wb_en;
    wb_sel_e    wb_sel;
    mem_size_e  mem_size;
    logic       mem_unsigned;
    logic       ebreak;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32/RV64 (+M) instruction decoder producing the
// control bundle and a sign-extended immediate.
module decode_comb
  import npc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int HAS_M = 1
) (
  input  logic [31:0]       inst,
  output logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   imm
);

  localparam bit RV32 = (XLEN == 32);
  localparam bit M_ON = (HAS_M != 0);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        is_m;
  logic        is_shift;
  logic        ill;
  logic [31:0] imm32;
  logic [63:0] imm64;
  ctrl_t       c;

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign is_m     = (inst[31:25] == 7'b0000001);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    c     = '0;
    imm32 = '0;
    ill   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        c.wb_en  = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_ALU;
        c.fu_op  = 5'b01111;
        imm32    = {inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        c.wb_en  = 1'b1;
        c.pc_en  = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_ALU;
        imm32    = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        c.wb_en  = 1'b1;
        c.wb_sel = WB_PC4;
        c.pc_en  = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_JAL;
        imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        c.wb_en  = 1'b1;
        c.wb_sel = WB_PC4;
        c.rs1_en = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_JALR;
        imm32    = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        c.rs1_en = 1'b1;
        c.rs2_en = 1'b1;
        c.pc_en  = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_BR;
        c.fu_op  = {2'b00, f3};
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LOAD: begin
        c.wb_en        = 1'b1;
        c.wb_sel       = WB_LOAD;
        c.rs1_en       = 1'b1;
        c.imm_en       = 1'b1;
        c.fu_sel       = FU_LOAD;
        c.mem_size     = mem_size_e'(f3[1:0]);
        c.mem_unsigned = f3[2];
        imm32          = {{20{inst[31]}}, inst[31:20]};
        ill = (f3 == 3'b111) || (RV32 && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OPC_STORE: begin
        c.rs1_en   = 1'b1;
        c.rs2_en   = 1'b1;
        c.imm_en   = 1'b1;
        c.fu_sel   = FU_STORE;
        c.mem_size = mem_size_e'(f3[1:0]);
        imm32      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ill = f3[2] || (RV32 && (f3 == 3'b011));
      end
      OPC_OP_IMM: begin
        c.wb_en  = 1'b1;
        c.rs1_en = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_ALU;
        c.fu_op  = {1'b0, is_shift & inst[30], f3};
        imm32    = {{20{inst[31]}}, inst[31:20]};
        ill = RV32 && is_shift && inst[25];
      end
      OPC_OP_IMM_32: begin
        c.wb_en  = 1'b1;
        c.rs1_en = 1'b1;
        c.imm_en = 1'b1;
        c.fu_sel = FU_ALUW;
        c.fu_op  = {1'b1, is_shift & inst[30], f3};
        imm32    = {{20{inst[31]}}, inst[31:20]};
        ill = RV32;
      end
      OPC_OP: begin
        c.wb_en  = 1'b1;
        c.rs1_en = 1'b1;
        c.rs2_en = 1'b1;
        c.fu_sel = is_m ? FU_MUL : FU_ALU;
        c.fu_op  = is_m ? {2'b00, f3} : {1'b0, inst[30], f3};
        ill = is_m && !M_ON;
      end
      OPC_OP_32: begin
        c.wb_en  = 1'b1;
        c.rs1_en = 1'b1;
        c.rs2_en = 1'b1;
        c.fu_sel = is_m ? FU_MULW : FU_ALUW;
        c.fu_op  = is_m ? {2'b10, f3} : {1'b1, inst[30], f3};
        ill = RV32 || (is_m && !M_ON);
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        c.fu_sel = FU_NONE;
      end
      default: ill = 1'b1;
    endcase

    // Register indices are zeroed whenever the corresponding port is unused.
    c.rs1    = c.rs1_en ? inst[19:15] : 5'd0;
    c.rs2    = c.rs2_en ? inst[24:20] : 5'd0;
    c.rd     = c.wb_en  ? inst[11:7]  : 5'd0;
    c.ebreak = (inst == EBREAK_INST);

    if (ill) begin
      c         = '0;
      c.fu_sel  = FU_NONE;
      c.illegal = 1'b1;
      imm32     = '0;
    end
  end

  assign imm64 = {{32{imm32[31]}}, imm32};
  assign imm   = imm64[XLEN-1:0];
  assign ctrl  = c;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input side and holds results in a
// two-entry main/skid buffer so in_ready comes straight from a flop.
module decode_stage
  import npc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int HAS_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_pc_en,
  output logic            out_imm_en,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_fu_sel,
  output logic [4:0]      out_fu_op,
  output logic            out_wb_en,
  output logic [1:0]      out_wb_sel,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_unsigned,
  output logic            out_ebreak,
  output logic            out_illegal
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  logic            main_valid;
  ctrl_t           main_ctrl;
  logic [XLEN-1:0] main_imm;
  logic [XLEN-1:0] main_pc;
  logic            skid_valid;
  ctrl_t           skid_ctrl;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_pc;
  logic            ready_q;
  logic            accept;

  decode_comb #(.XLEN(XLEN), .HAS_M(HAS_M)) u_decode (
    .inst (in_inst),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign accept = in_valid & ready_q;

  // Skid only ever fills while main is stalled, so FIFO order is main then skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_imm   <= '0;
      main_pc    <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_imm   <= '0;
      skid_pc    <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_imm   <= skid_imm;
        main_pc    <= skid_pc;
        skid_valid <= accept;
        ready_q    <= !accept;
        if (accept) begin
          skid_ctrl <= dec_ctrl;
          skid_imm  <= dec_imm;
          skid_pc   <= in_pc;
        end
      end else begin
        main_valid <= accept;
        ready_q    <= 1'b1;
        if (accept) begin
          main_ctrl <= dec_ctrl;
          main_imm  <= dec_imm;
          main_pc   <= in_pc;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= dec_ctrl;
      skid_imm   <= dec_imm;
      skid_pc    <= in_pc;
      ready_q    <= 1'b0;
    end
  end

  assign in_ready         = ready_q;
  assign out_valid        = main_valid;
  assign out_pc           = main_pc;
  assign out_imm          = main_imm;
  assign out_rs1          = main_ctrl.rs1;
  assign out_rs2          = main_ctrl.rs2;
  assign out_rd           = main_ctrl.rd;
  assign out_rs1_en       = main_ctrl.rs1_en;
  assign out_rs2_en       = main_ctrl.rs2_en;
  assign out_pc_en        = main_ctrl.pc_en;
  assign out_imm_en       = main_ctrl.imm_en;
  assign out_fu_sel       = main_ctrl.fu_sel;
  assign out_fu_op        = main_ctrl.fu_op;
  assign out_wb_en        = main_ctrl.wb_en;
  assign out_wb_sel       = main_ctrl.wb_sel;
  assign out_mem_size     = main_ctrl.mem_size;
  assign out_mem_unsigned = main_ctrl.mem_unsigned;
  assign out_ebreak       = main_ctrl.ebreak;
  assign out_illegal      = main_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Drives an RV64+M and an RV32 no-M decode_stage side by side and checks both
// against an ISA-level decode model and a two-deep FIFO occupancy model.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        pc_en;
    logic        imm_en;
    logic [3:0]  fu_sel;
    logic [4:0]  fu_op;
    logic        wb_en;
    logic [1:0]  wb_sel;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        ebreak;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [63:0] pc_ctr = 64'h1000;

  int compared = 0;
  int mismatched = 0;
  ent_t q[$];

  logic        rdy64, v64, rdy32, v32;
  logic [63:0] pc64, imm64o;
  logic [31:0] pc32, imm32o;
  logic [4:0]  rs1_64, rs2_64, rd_64, op_64, rs1_32, rs2_32, rd_32, op_32;
  logic        rs1e_64, rs2e_64, pce_64, imme_64, wbe_64, mu_64, eb_64, il_64;
  logic        rs1e_32, rs2e_32, pce_32, imme_32, wbe_32, mu_32, eb_32, il_32;
  logic [3:0]  fu_64, fu_32;
  logic [1:0]  wbs_64, ms_64, wbs_32, ms_32;
  exp_t        obs64, obs32;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .HAS_M(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_pc(pc_ctr), .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd_64),
    .out_rs1_en(rs1e_64), .out_rs2_en(rs2e_64), .out_pc_en(pce_64), .out_imm_en(imme_64),
    .out_imm(imm64o), .out_fu_sel(fu_64), .out_fu_op(op_64), .out_wb_en(wbe_64),
    .out_wb_sel(wbs_64), .out_mem_size(ms_64), .out_mem_unsigned(mu_64),
    .out_ebreak(eb_64), .out_illegal(il_64)
  );

  decode_stage #(.XLEN(32), .HAS_M(0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_pc(pc_ctr[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd_32),
    .out_rs1_en(rs1e_32), .out_rs2_en(rs2e_32), .out_pc_en(pce_32), .out_imm_en(imme_32),
    .out_imm(imm32o), .out_fu_sel(fu_32), .out_fu_op(op_32), .out_wb_en(wbe_32),
    .out_wb_sel(wbs_32), .out_mem_size(ms_32), .out_mem_unsigned(mu_32),
    .out_ebreak(eb_32), .out_illegal(il_32)
  );

  assign obs64 = {imm64o, rs1_64, rs2_64, rd_64, rs1e_64, rs2e_64, pce_64, imme_64,
                  fu_64, op_64, wbe_64, wbs_64, ms_64, mu_64, eb_64, il_64};
  assign obs32 = {32'h0, imm32o, rs1_32, rs2_32, rd_32, rs1e_32, rs2e_32, pce_32, imme_32,
                  fu_32, op_32, wbe_32, wbs_32, ms_32, mu_32, eb_32, il_32};

  // ISA-level reference decode, written from the instruction-set rules.
  function automatic exp_t model(logic [31:0] w, bit rv64, bit has_m);
    exp_t e;
    int op = int'(w[6:0]);
    int f3 = int'(w[14:12]);
    int alt = w[30] ? 8 : 0;
    bit mext = (w[31:25] == 7'd1);
    bit shift = (f3 == 1) || (f3 == 5);
    bit bad = 1'b0;
    logic [12:0] bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    logic [20:0] jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    logic [11:0] simm = {w[31:25], w[11:7]};
    logic [31:0] uimm = {w[31:12], 12'h000};
    logic [63:0] iimm = 64'($signed(w[31:20]));
    e = '0;
    case (op)
      'h37: begin e.wb_en = 1; e.imm_en = 1; e.fu_op = 5'd15; e.imm = 64'($signed(uimm)); end
      'h17: begin e.wb_en = 1; e.pc_en = 1; e.imm_en = 1; e.imm = 64'($signed(uimm)); end
      'h6F: begin e.wb_en = 1; e.wb_sel = 2; e.pc_en = 1; e.imm_en = 1; e.fu_sel = 5;
                  e.imm = 64'($signed(jimm)); end
      'h67: begin e.wb_en = 1; e.wb_sel = 2; e.rs1_en = 1; e.imm_en = 1; e.fu_sel = 6;
                  e.imm = iimm; end
      'h63: begin e.rs1_en = 1; e.rs2_en = 1; e.pc_en = 1; e.imm_en = 1; e.fu_sel = 4;
                  e.fu_op = 5'(f3); e.imm = 64'($signed(bimm)); end
      'h03: begin e.wb_en = 1; e.wb_sel = 1; e.rs1_en = 1; e.imm_en = 1; e.fu_sel = 7;
                  e.mem_size = 2'(f3 % 4); e.mem_unsigned = (f3 >= 4); e.imm = iimm;
                  bad = (f3 == 7) || (!rv64 && (f3 == 3 || f3 == 6)); end
      'h23: begin e.rs1_en = 1; e.rs2_en = 1; e.imm_en = 1; e.fu_sel = 8;
                  e.mem_size = 2'(f3 % 4); e.imm = 64'($signed(simm));
                  bad = (f3 > 3) || (!rv64 && f3 == 3); end
      'h13: begin e.wb_en = 1; e.rs1_en = 1; e.imm_en = 1; e.imm = iimm;
                  e.fu_op = 5'(shift ? alt + f3 : f3); bad = !rv64 && shift && w[25]; end
      'h1B: begin e.wb_en = 1; e.rs1_en = 1; e.imm_en = 1; e.imm = iimm; e.fu_sel = 1;
                  e.fu_op = 5'(16 + (shift ? alt : 0) + f3); bad = !rv64; end
      'h33: begin e.wb_en = 1; e.rs1_en = 1; e.rs2_en = 1;
                  e.fu_sel = mext ? 4'd2 : 4'd0; e.fu_op = 5'(mext ? f3 : alt + f3);
                  bad = mext && !has_m; end
      'h3B: begin e.wb_en = 1; e.rs1_en = 1; e.rs2_en = 1;
                  e.fu_sel = mext ? 4'd3 : 4'd1; e.fu_op = 5'(mext ? 16 + f3 : 16 + alt + f3);
                  bad = !rv64 || (mext && !has_m); end
      'h0F, 'h73: begin e.fu_sel = 9; e.ebreak = (w == 32'h00100073); end
      default: bad = 1'b1;
    endcase
    if (e.rs1_en) e.rs1 = w[19:15];
    if (e.rs2_en) e.rs2 = w[24:20];
    if (e.wb_en)  e.rd  = w[11:7];
    if (bad) begin
      e = '0;
      e.fu_sel = 9;
      e.illegal = 1'b1;
    end
    if (!rv64) e.imm = {32'h0, e.imm[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73};
    logic [31:0] w = $urandom();
    int sel = $urandom_range(0, 17);
    if (sel < 13) begin
      w[6:0] = ops[sel];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h01;
        1: w[31:25] = {1'b0, w[30], 5'b0};
        default: ;
      endcase
    end else if (sel == 13) begin
      w = 32'h00100073;
    end
    return w;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBundle(input string who, input exp_t o, input exp_t e);
    cmp({who, ".imm"},    o.imm, e.imm);
    cmp({who, ".rs1"},    64'(o.rs1), 64'(e.rs1));
    cmp({who, ".rs2"},    64'(o.rs2), 64'(e.rs2));
    cmp({who, ".rd"},     64'(o.rd), 64'(e.rd));
    cmp({who, ".en"},     64'({o.rs1_en, o.rs2_en, o.pc_en, o.imm_en}),
                          64'({e.rs1_en, e.rs2_en, e.pc_en, e.imm_en}));
    cmp({who, ".fu_sel"}, 64'(o.fu_sel), 64'(e.fu_sel));
    cmp({who, ".fu_op"},  64'(o.fu_op), 64'(e.fu_op));
    cmp({who, ".wb"},     64'({o.wb_en, o.wb_sel}), 64'({e.wb_en, e.wb_sel}));
    cmp({who, ".mem"},    64'({o.mem_size, o.mem_unsigned}), 64'({e.mem_size, e.mem_unsigned}));
    cmp({who, ".flags"},  64'({o.ebreak, o.illegal}), 64'({e.ebreak, e.illegal}));
  endtask

  task automatic checkOutput();
    cmp("in_ready64",  64'(rdy64), 64'(q.size() < 2));
    cmp("out_valid64", 64'(v64),   64'(q.size() > 0));
    cmp("in_ready32",  64'(rdy32), 64'(q.size() < 2));
    cmp("out_valid32", 64'(v32),   64'(q.size() > 0));
    if (q.size() > 0) begin
      checkBundle("dut64", obs64, model(q[0].inst, 1'b1, 1'b1));
      cmp("pc64", pc64, q[0].pc);
      checkBundle("dut32", obs32, model(q[0].inst, 1'b0, 1'b0));
      cmp("pc32", 64'(pc32), 64'(q[0].pc[31:0]));
    end
  endtask

  // One clock of stimulus: check pre-edge outputs, then advance the FIFO model.
  task automatic applyStimulus(input logic r, input logic fl, input logic v,
                               input logic [31:0] w, input logic ordy);
    bit acc, pop;
    rst = r; flush = fl; in_valid = v; in_inst = w; out_ready = ordy;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    if (r || fl) q.delete();
    else begin
      if (pop) q.delete(0);
      if (acc) q.push_back('{w, pc_ctr});
    end
    #1;
    pc_ctr = pc_ctr + 64'd4;
  endtask

  initial begin
    exp_t zero;
    zero = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_valid64", 64'(v64), 64'd0);
    cmp("rst_ready64", 64'(rdy64), 64'd1);
    cmp("rst_pc64", pc64, 64'd0);
    checkBundle("rst64", obs64, zero);
    checkBundle("rst32", obs32, zero);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00500093, 1'b1);
    cmp("addi_fu_sel", 64'(fu_64), 64'd0);
    cmp("addi_fu_op", 64'(op_64), 64'd0);
    cmp("addi_rd", 64'(rd_64), 64'd1);
    cmp("addi_rs1", 64'(rs1_64), 64'd0);
    cmp("addi_imm", imm64o, 64'd5);
    cmp("addi_wb", 64'({wbe_64, wbs_64}), 64'b100);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0010009B, 1'b1);
    cmp("addiw32_illegal", 64'({il_32, wbe_32, fu_32}), 64'({1'b1, 1'b0, 4'd9}));
    cmp("addiw64_fu", 64'({fu_64, op_64}), 64'({4'd1, 5'b10000}));

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h02208033, 1'b1);
    cmp("mul_nom_illegal", 64'(il_32), 64'd1);
    cmp("mul64_fu", 64'({fu_64, op_64, il_64}), 64'({4'd2, 5'd0, 1'b0}));

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFE000EE3, 1'b1);
    cmp("beq64_imm", imm64o, 64'hFFFF_FFFF_FFFF_FFFC);
    cmp("beq32_imm", 64'(imm32o), 64'hFFFF_FFFC);
    cmp("beq_rs2_en", 64'({rs2e_64, rs2e_32}), 64'b11);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00100073, 1'b1);
    cmp("ebreak", 64'({eb_64, wbe_64, eb_32, wbe_32}), 64'b1010);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure: four instructions offered while execute stalls for 3 cycles.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00100113, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00200193, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00300213, 1'b0);
    cmp("stall_in_ready", 64'({rdy64, rdy32}), 64'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00300213, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00300213, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400293, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush with main and skid full and a new instruction offered.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00A00313, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00B00393, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h00C00413, 1'b0);
    cmp("flush_state", 64'({v64, rdy64, v32, rdy32}), 64'b0101);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 75, randInst(), $urandom_range(0, 99) < 65);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32/RV64 instruction decode stage for the NPC core, sitting between fetch and execute. It decodes one instruction per cycle into a control bundle with a fully generated immediate, and flags illegal encodings for the selected XLEN and extension set. A valid/ready handshake with a two-entry skid buffer keeps `in_ready` registered, and a flush input discards in-flight entries.

## Interface
- `XLEN`, 64: datapath width; legal values are 32 or 64. RV32 mode makes W-opcodes, `ld`, `lwu` and `sd` illegal.
- `HAS_M`, 1: when 0, every M-extension encoding is illegal.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discards all held entries this cycle.
- `in_valid`  in  1  fetch is presenting an instruction.
- `in_ready`  out  1  stage accepts; driven straight from a register.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of that instruction.
- `out_valid`  out  1  a decoded bundle is presented.
- `out_ready`  in  1  execute accepts.
- `out_pc`  out  XLEN  PC of the bundle.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices. Each index is forced to 0 when its enable is 0.
- `out_rs1_en`, `out_rs2_en`, `out_pc_en`, `out_imm_en`  out  1 each  operand-select enables.
- `out_imm`  out  XLEN  sign-extended I/S/B/U/J immediate; 0 for R-type.
- `out_fu_sel`  out  4  functional-unit code from `npc_pkg`.
- `out_fu_op`  out  5  unit operation code.
- `out_wb_en`  out  1  register write-back enable.
- `out_wb_sel`  out  2  write-back source: 0 ALU, 1 load, 2 PC+4.
- `out_mem_size`  out  2  memory access size: 0 byte, 1 half, 2 word, 3 double.
- `out_mem_unsigned`  out  1  zero-extend the load result.
- `out_ebreak`  out  1  instruction is `ebreak`.
- `out_illegal`  out  1  instruction is illegal for this configuration.

## Operation
- **Decode path:** `decode_comb` decodes `in_inst` combinationally. The result is captured together with `in_pc` on acceptance, defined as `in_valid & in_ready`.
- **`fu_sel` codes:** ALU=0, ALUW=1, MUL=2, MULW=3, BR=4, JAL=5, JALR=6, LOAD=7, STORE=8, NONE=9.
- **`fu_op` encoding:**
  - Register ALU ops and immediate shifts: `{0, inst[30], funct3}`.
  - Immediate non-shift ops: `{0, 0, funct3}`.
  - `lui`: 5'b01111.
  - `auipc`, JAL, JALR, LOAD, STORE: 0.
  - BR and MUL: `{00, funct3}`.
  - ALUW and MULW: `{1, inst[30] or 0 per the ALU rules, funct3}`.
- **Illegal encodings:**
  - Opcode outside RV64IM base.
  - Load `funct3` = 111, or store `funct3` above 011.
  - In RV32 mode: `shamt[5]=1`, any W opcode, `ld`, `lwu` or `sd`.
  - `HAS_M=0` with `funct7=0000001` on opcode 0110011 or 0111011.
- **Illegal bundle contents:** `wb_en=0`, `fu_sel=NONE`, `illegal=1`. The bundle still flows through the stage normally.
- **`ebreak`:** exactly 0x00100073. It sets `fu_sel=NONE` and `wb_en=0`.
- **Skid buffer:** two entries.
  - `main` drives the outputs.
  - `skid` catches an accepted instruction when `main` is full and `out_ready=0`.
  - `in_ready` register equals `!skid_valid`.
- **Per-cycle update, in priority order:**
  1. `rst` or `flush`: both valid bits are cleared and the accept in that cycle is dropped.
  2. `main` empty, or `main` full with `out_ready=1`: `main` loads from `skid` if `skid` is full, otherwise from the input. If `main` loaded from `skid`, a simultaneous accept is written into `skid`.
  3. `main` full and `out_ready=0`: an accept is written into `skid`.
- **Ordering:** strict FIFO order is always preserved.

## Timing
- **Reset values:** `out_valid=0`, `in_ready=1`, all bundle fields 0.
- **Latency:** 1 cycle. An instruction accepted at edge N is on the outputs after edge N.
- **Throughput:** 1 instruction/cycle while `out_ready=1`.
- **Outputs:** change only on clock edges and stay stable while `out_valid & !out_ready`.
- **`in_ready` after a stall:** falls the cycle after `skid` fills. It rises the cycle after `skid` drains into `main`.
- **Flush:** `flush` with `out_valid=1` gives `out_valid=0` on the next cycle and `in_ready=1`.
- **Reset mid-stall:** behaves identically to flush.

## Structure
- **`npc_pkg`:** opcode constants, `fu_sel` codes, `wb_sel` codes and `mem_size` codes.
- **`decode_comb` (purely combinational, parameters `XLEN`, `HAS_M`):** produces the full bundle plus `illegal`.
- **`decode_stage` (top):** holds only the skid and handshake registers and instantiates `decode_comb` once, on the input side.

## Test plan
- **Basic decode:** 0x00500093 (`addi x1,x0,5`) -> `fu_sel=ALU`, `fu_op=0`, `rd=1`, `rs1=0`, `imm=5`, `wb_en=1`, `wb_sel=0`, one cycle later.
- **Illegal in RV32:** `XLEN=32`, 0x0010009B (`addiw`) -> `illegal=1`, `wb_en=0`, `fu_sel=NONE`. With `XLEN=64`: `fu_sel=ALUW`, `fu_op=5'b10000`.
- **M extension gating:** `HAS_M=0`, 0x02208033 (`mul x0,x1,x2`) -> `illegal=1`. With `HAS_M=1`: `fu_sel=MUL`, `fu_op=0`.
- **Immediates and `ebreak`:**
  - 0xFE000EE3 (`beq x0,x0,-4`) -> `imm=-4` sign-extended to `XLEN`, `rs2_en=1`.
  - 0x00100073 -> `ebreak=1`, `wb_en=0`.
- **Backpressure:**
  - Stimulus: stream of 4 instructions with `in_valid=1`, `out_ready=0` for 3 cycles.
  - Response: `main` and `skid` fill and `in_ready=0` for the remainder of the stall.
  - After release: all 4 emerge in order with no duplication or loss.
- **Flush:** `flush` with `main` and `skid` full plus an `in_valid` the same cycle -> next cycle `out_valid=0`, `in_ready=1`, and none of the 3 instructions ever appear.
